// File: rtl/bus_unpack_pkg.sv
// Shared types and helpers for the bus unpack serializer.
package bus_unpack_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // A WIDTH of 2 still needs one counter bit.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/bus_unpack_bitcnt.sv
// Bit-position counter for one word: clears on a new word, saturates at WIDTH-1.
module bus_unpack_bitcnt
   import bus_unpack_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic incr,
   output logic is_last
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (incr && (cnt_q != LAST))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign is_last = (cnt_q == LAST);

endmodule

// File: rtl/bus_unpack_serializer.sv
// Unpacks a WIDTH-bit word into a ready/valid bit stream, MSB- or LSB-first,
// with zero-bubble back-to-back word acceptance on the last bit beat.
module bus_unpack_serializer
   import bus_unpack_pkg::*;
#(
   parameter int WIDTH     = 2,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] source_bus,
   input  logic             source_valid,
   output logic             source_ready,
   output logic             scalar_out,
   output logic             scalar_valid,
   input  logic             scalar_ready,
   output logic             scalar_last,
   output logic             busy
);

   localparam int OUT_BIT = MSB_FIRST ? WIDTH - 1 : 0;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             is_last;
   logic             bit_beat;
   logic             word_hs;

   assign busy         = (state_q == SHIFT);
   assign scalar_valid = busy;
   assign scalar_last  = busy && is_last;
   assign scalar_out   = shreg_q[OUT_BIT];
   assign source_ready = !busy || (is_last && scalar_ready);
   assign bit_beat     = busy && scalar_ready;
   assign word_hs      = source_valid && source_ready;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      if (word_hs) begin
         state_d = SHIFT;
         shreg_d = source_bus;
      end else if (bit_beat) begin
         shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
         if (is_last)
            state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

   // Finishing a word also returns the counter to 0 so IDLE never reports last.
   bus_unpack_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (word_hs || (bit_beat && is_last)),
      .incr    (bit_beat),
      .is_last (is_last)
   );

endmodule

// File: tb/tb_bus_unpack_serializer.sv
// Directed bench: four serializer configurations driven by one linear sequence.
module tb_bus_unpack_serializer;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // W=2, MSB first
   logic [1:0] sb2;
   logic sv2, sr2, so2, vo2, rdy2, lst2, bsy2;
   // W=8, LSB first
   logic [7:0] sbl;
   logic svl, srl, sol, vol, rdyl, lstl, bsyl;
   // W=8, MSB first
   logic [7:0] sbm;
   logic svm, srm, som, vom, rdym, lstm, bsym;
   // W=4, MSB first
   logic [3:0] sb4;
   logic sv4, sr4, so4, vo4, rdy4, lst4, bsy4;

   bus_unpack_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_w2 (
      .clk(clk), .rst_n(rst_n), .source_bus(sb2), .source_valid(sv2), .source_ready(sr2),
      .scalar_out(so2), .scalar_valid(vo2), .scalar_ready(rdy2), .scalar_last(lst2), .busy(bsy2));
   bus_unpack_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_w8l (
      .clk(clk), .rst_n(rst_n), .source_bus(sbl), .source_valid(svl), .source_ready(srl),
      .scalar_out(sol), .scalar_valid(vol), .scalar_ready(rdyl), .scalar_last(lstl), .busy(bsyl));
   bus_unpack_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8m (
      .clk(clk), .rst_n(rst_n), .source_bus(sbm), .source_valid(svm), .source_ready(srm),
      .scalar_out(som), .scalar_valid(vom), .scalar_ready(rdym), .scalar_last(lstm), .busy(bsym));
   bus_unpack_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4 (
      .clk(clk), .rst_n(rst_n), .source_bus(sb4), .source_valid(sv4), .source_ready(sr4),
      .scalar_out(so4), .scalar_valid(vo4), .scalar_ready(rdy4), .scalar_last(lst4), .busy(bsy4));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle-state check on every instance.
   task automatic chk_idle(input string tag);
      chk({tag, " w2"},  {sr2, vo2, so2, lst2, bsy2}, 8'b10000);
      chk({tag, " w8l"}, {srl, vol, sol, lstl, bsyl}, 8'b10000);
      chk({tag, " w8m"}, {srm, vom, som, lstm, bsym}, 8'b10000);
      chk({tag, " w4"},  {sr4, vo4, so4, lst4, bsy4}, 8'b10000);
   endtask

   initial begin
      logic [7:0] w;
      rst_n = 1'b0;
      sb2 = '0; sv2 = 0; rdy2 = 0;
      sbl = '0; svl = 0; rdyl = 0;
      sbm = '0; svm = 0; rdym = 0;
      sb4 = '0; sv4 = 0; rdy4 = 0;

      // Reset, then three idle cycles after release
      #3;
      chk_idle("reset");
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick(); tick();
      chk_idle("post_reset_idle");

      // W=2, MSB first, 2'b10
      sv2 = 1; sb2 = 2'b10; rdy2 = 1;
      #1 chk("w2 ready_idle", sr2, 1);
      tick();
      sv2 = 0; sb2 = 2'b01;
      chk("w2 beat1 {vld,out,last,busy}", {vo2, so2, lst2, bsy2}, 8'b1101);
      tick();
      chk("w2 beat2 {vld,out,last,busy}", {vo2, so2, lst2, bsy2}, 8'b1011);
      tick();
      chk("w2 done {vld,busy}", {vo2, bsy2}, 8'b00);

      // W=8, LSB first, 8'hA5 -> 1,0,1,0,0,1,0,1
      svl = 1; sbl = 8'hA5; rdyl = 1;
      tick();
      svl = 0; sbl = 8'h00;
      w = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("w8l bit%0d {vld,out,last}", i), {vol, sol, lstl},
             {5'd0, 1'b1, w[i], (i == 7)});
         tick();
      end
      chk("w8l done {vld,busy}", {vol, bsyl}, 8'b00);

      // W=8, MSB first, 8'h3C with a 4-cycle stall after beat 3
      svm = 1; sbm = 8'h3C; rdym = 1;
      tick();
      svm = 0; sbm = 8'hFF;
      w = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            rdym = 0;
            for (int s = 0; s < 4; s++) begin
               #1 chk($sformatf("stall%0d {vld,out,last,busy,srdy}", s),
                      {vom, som, lstm, bsym, srm}, 8'b11010);
               tick();
            end
            rdym = 1;
         end
         chk($sformatf("w8m stall-seq bit%0d {vld,out,last}", i), {vom, som, lstm},
             {5'd0, 1'b1, w[7-i], (i == 7)});
         tick();
      end
      chk("w8m stall done {vld,busy}", {vom, bsym}, 8'b00);

      // W=4 back-to-back: 4'hF then 4'h0 with source_valid held
      sv4 = 1; sb4 = 4'hF; rdy4 = 1;
      #1 chk("b2b ready_idle", sr4, 1);
      tick();
      sb4 = 4'h0;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) sv4 = 0;
         #1;
         chk($sformatf("b2b beat%0d {vld,out,last,srdy}", i), {vo4, so4, lst4, sr4},
             {4'd0, 1'b1, (i < 4), (i == 3 || i == 7), (i == 3 || i == 7)});
         tick();
      end
      chk("b2b done {vld,busy}", {vo4, bsy4}, 8'b00);

      // Reset mid-word on W=8 MSB first, then a clean 8'h81
      svm = 1; sbm = 8'hFF; rdym = 1;
      tick();
      svm = 0;
      tick(); tick(); tick();
      chk("pre-abort {vld,out,busy}", {vom, som, bsym}, 8'b111);
      rst_n = 1'b0;
      #1 chk("abort async {srdy,vld,out,last,busy}", {srm, vom, som, lstm, bsym}, 8'b10000);
      tick();
      rst_n = 1'b1;
      tick();
      chk("abort held idle", {vom, lstm, bsym}, 8'b000);
      svm = 1; sbm = 8'h81;
      tick();
      svm = 0; sbm = 8'h00;
      w = 8'h81;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("post-abort bit%0d {vld,out,last}", i), {vom, som, lstm},
             {5'd0, 1'b1, w[7-i], (i == 7)});
         tick();
      end
      chk("post-abort done {vld,busy}", {vom, bsym}, 8'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bus_unpack_serializer.md
# bus_unpack_serializer

Unpacks a parallel bus word into a stream of scalar bits, one bit per accepted beat on a scalar output. It is the reading counterpart of the scalar-into-bus append path:
- that path assembles a bus from bus slices and a scalar;
- this block takes an assembled bus and drives its bits back out on a scalar net.

It sits between a word-wide producer and a bit-serial consumer. Ready/valid handshakes are used on both sides.

## Interface
Parameters:
- WIDTH, 2, bus width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = emit bit WIDTH-1 first; 0 = emit bit 0 first.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- source_bus  input  WIDTH  word to unpack; sampled on word handshake.
- source_valid  input  1  source_bus holds a word.
- source_ready  output  1  block can accept a word.
- scalar_out  output  1  current serial bit.
- scalar_valid  output  1  scalar_out is valid.
- scalar_ready  input  1  consumer accepts scalar_out this cycle.
- scalar_last  output  1  scalar_out is the final bit of the word.
- busy  output  1  a word is held and not fully emitted.

## Operation
- States: IDLE, SHIFT.
- IDLE:
  - source_ready=1, scalar_valid=0.
  - On source_valid&&source_ready, latch source_bus into shift register, clear bit counter to 0, go to SHIFT.
- SHIFT:
  - scalar_valid=1.
  - scalar_out = shift register MSB when MSB_FIRST=1, else LSB.
  - scalar_last=1 when counter==WIDTH-1.
- Bit beat:
  - A bit beat is scalar_valid&&scalar_ready.
  - On each bit beat, shift the register by one toward the output end and increment the counter.
  - On a bit beat while scalar_last=1, the word is complete. Go to IDLE, unless a new word is accepted in the same cycle (see below).
- Back-to-back:
  - In SHIFT, source_ready = scalar_last && scalar_ready.
  - If source_valid is also high in that cycle, latch the new word, reset the counter, and stay in SHIFT. There is no idle bubble between words.
- Stall: while scalar_valid=1 and scalar_ready=0, scalar_out, scalar_last, the counter and the register hold steady.
- busy = (state==SHIFT).
- Counter width: $clog2(WIDTH). The counter never exceeds WIDTH-1, so no wrap past WIDTH-1 occurs.
- source_bus is ignored outside the word handshake cycle.

## Timing
- Reset (asynchronous assert, synchronous-style release on the next clk edge after rst_n rises):
  - state=IDLE, counter=0, shift register=0;
  - source_ready=1, scalar_valid=0, scalar_out=0, scalar_last=0, busy=0.
- Latency:
  - Word accepted at edge N → first bit valid in the cycle after edge N.
  - With scalar_ready held at 1, a word occupies exactly WIDTH cycles.
- Throughput: one bit per cycle; continuous words with zero gap.
- source_ready is combinational from state, scalar_last and scalar_ready. There is no combinational path from source_valid to any output.
- Reset mid-word: the partial word is discarded and outputs return to reset values immediately. No scalar_last is emitted for the aborted word.
- WIDTH=2 with MSB_FIRST=1 emits bit1 then bit0, matching the bit order of a two-bit sink bus.

## Structure
- Shared package bus_unpack_pkg holds:
  - state enum (IDLE, SHIFT);
  - function computing counter width from WIDTH.
- One natural sub-module: bus_unpack_bitcnt.
  - Parameterised WIDTH-range counter.
  - Inputs: clear, increment.
  - Output: is_last.
- Shift register, FSM and handshake logic stay in the top module.

## Test plan
- Reset: hold rst_n=0 → source_ready=1, scalar_valid=0, busy=0. Release, wait 3 cycles idle → outputs unchanged.
- Single word, WIDTH=2, MSB_FIRST=1, source_bus=2'b10, scalar_ready=1 → scalar_out 1 then 0; scalar_last high only on the second beat; busy falls after 2 cycles.
- LSB-first, WIDTH=8, MSB_FIRST=0, word 8'hA5 → serial bits 1,0,1,0,0,1,0,1; scalar_last on beat 8.
- Stall: WIDTH=8, word 8'h3C, scalar_ready deasserted for 4 cycles after beat 3 → scalar_out, scalar_last and busy hold. The full sequence resumes intact.
- Back-to-back: WIDTH=4, words 4'hF then 4'h0 with source_valid held high → 8 consecutive valid bits (1111 0000). source_ready pulses only on the last-bit beat; there is no idle cycle.
- Reset mid-word: WIDTH=8, assert rst_n=0 after beat 3 → scalar_valid=0 asynchronously. After release, a new word 8'h81 emits cleanly from bit 7.
